wc_tile_loader: RTL and testbench



---
 rtl/wc_pkg.sv | 12 +
 rtl/wc_tile_slot.sv | 37 +++
 rtl/wc_tile_loader.sv | 99 +++++++++
 tb/tb_wc_tile_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wc_pkg.sv
// Shared constants and the packed tile word type for the Winograd core and its loader.
package wc_pkg;

  localparam int WC_PIX_W  = 8;
  localparam int WC_TILE   = 10;
  localparam int WC_OVL    = 3;
  localparam int WC_STRIDE = WC_TILE - WC_OVL;
  localparam int WC_TILE_W = WC_TILE * WC_PIX_W;

  typedef logic [WC_TILE_W-1:0] wc_tile_t;

endpackage

// File: rtl/wc_tile_slot.sv
// Single-entry output holding register for assembled tiles: load, hold, drain and a free flag.
module wc_tile_slot
  import wc_pkg::*;
#(
  parameter int W = WC_TILE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         tile_ready,
  output logic [W-1:0] tile_data,
  output logic         tile_valid,
  output logic         tile_last,
  output logic         free
);

  // A draining slot counts as free so a new tile can replace it without a bubble.
  assign free = !tile_valid || tile_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_data  <= '0;
      tile_valid <= 1'b0;
      tile_last  <= 1'b0;
    end else if (load) begin
      tile_data  <= load_data;
      tile_valid <= 1'b1;
      tile_last  <= load_last;
    end else if (tile_ready) begin
      tile_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wc_tile_loader.sv
// Assembles overlapping 1-D pixel tiles from a serial stream for the Winograd core.
// Build option: WC_ZERO_PAD_EN zero-fills and emits a partial window at row end instead of dropping it.
module wc_tile_loader
  import wc_pkg::*;
#(
  parameter int PIX_W = WC_PIX_W,
  parameter int TILE  = WC_TILE,
  parameter int OVL   = WC_OVL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [TILE*PIX_W-1:0] tile_data,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic                  tile_last
);

  localparam int            CW     = $clog2(TILE + 1);
  localparam logic [CW-1:0] TILE_C = CW'(TILE);
  localparam logic [CW-1:0] OVL_C  = CW'(OVL);

  logic [PIX_W-1:0]      win   [TILE];
  logic [PIX_W-1:0]      win_n [TILE];
  logic [CW-1:0]         cnt, cnt_n;
  logic                  pend_last, last_n;
  logic                  accept, slot_free, load;
  logic [TILE*PIX_W-1:0] tile_w;

  assign in_ready = (cnt < TILE_C);
  assign accept   = in_valid && in_ready;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    win_n  = win;
    cnt_n  = cnt;
    last_n = pend_last;
    if (accept) begin
      for (int i = 0; i < TILE; i++)
        if (cnt == CW'(i)) win_n[i] = in_data;
      cnt_n = cnt + 1'b1;
      if (in_last) begin
        last_n = 1'b1;
        if (cnt_n != TILE_C) begin
`ifdef WC_ZERO_PAD_EN
          for (int i = 0; i < TILE; i++)
            if (CW'(i) > cnt) win_n[i] = '0;
          cnt_n = TILE_C;
`else
          cnt_n  = '0;
          last_n = 1'b0;
`endif
        end
      end
    end
    load = (cnt_n == TILE_C) && slot_free;
    for (int i = 0; i < TILE; i++)
      tile_w[i*PIX_W +: PIX_W] = win_n[i];
  end

  // NOTE: the window is reset too, so a tile built after reset never exposes stale pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TILE; i++) win[i] <= '0;
      cnt       <= '0;
      pend_last <= 1'b0;
    end else if (load) begin
      pend_last <= 1'b0;
      if (last_n) begin
        // Row end: nothing carries into the next row.
        cnt <= '0;
      end else begin
        cnt <= OVL_C;
        for (int i = 0; i < OVL; i++) win[i] <= win_n[TILE-OVL+i];
      end
    end else begin
      win       <= win_n;
      cnt       <= cnt_n;
      pend_last <= last_n;
    end
  end

  wc_tile_slot #(.W(TILE*PIX_W)) u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (tile_w),
    .load_last  (last_n),
    .tile_ready (tile_ready),
    .tile_data  (tile_data),
    .tile_valid (tile_valid),
    .tile_last  (tile_last),
    .free       (slot_free)
  );

endmodule

// File: tb/tb_wc_tile_loader.sv
// Directed self-checking bench for wc_tile_loader; row-end expectations follow WC_ZERO_PAD_EN.
module tb_wc_tile_loader;
  import wc_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic [79:0]    tile_data;
  logic           tile_valid;
  logic           tile_ready = 1'b0;
  logic           tile_last;

  int checks = 0;
  int failures = 0;
  logic [80:0] got_q [$];
  logic [80:0] exp_q [$];

  wc_tile_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .tile_data  (tile_data),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_last  (tile_last)
  );

  always #5 clk = ~clk;

  // Record every tile handshake as {tile_last, tile_data}.
  always @(posedge clk)
    if (rst && tile_valid && tile_ready) got_q.push_back({tile_last, tile_data});

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic wc_tile_t seq_tile(input int first);
    wc_tile_t t;
    for (int i = 0; i < WC_TILE; i++) t[i*8 +: 8] = 8'(first + i);
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] v, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_tiles(input string tag);
    check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_t%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
  endtask

  initial begin
    wc_tile_t pad;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 1);
    check("rst_tile_valid", 128'(tile_valid), 0);
    check("rst_tile_last", 128'(tile_last), 0);
    check("rst_tile_data", 128'(tile_data), 0);
    rst = 1'b1;

    // Free-running stream 1..17
    do_reset();
    tile_ready = 1'b1;
    for (int v = 1; v <= 17; v++) begin
      send(8'(v), 1'b0);
      if (v == 10) begin
        #1;
        check("lat_valid", 128'(tile_valid), 1);
        check("lat_data", 128'(tile_data), 128'(seq_tile(1)));
      end
    end
    idle(3);
    exp_q.push_back({1'b0, seq_tile(1)});
    exp_q.push_back({1'b0, seq_tile(8)});
    check_tiles("stream");

    // Back-pressure: tile0 held, window fills, drain and reload in the same cycle
    do_reset();
    tile_ready = 1'b0;
    for (int v = 1; v <= 17; v++) send(8'(v), 1'b0);
    idle(0);
    check("bp_in_ready_low", 128'(in_ready), 0);
    check("bp_hold_valid", 128'(tile_valid), 1);
    check("bp_hold_data", 128'(tile_data), 128'(seq_tile(1)));
    repeat (3) @(negedge clk);
    check("bp_hold_stable", 128'(tile_data), 128'(seq_tile(1)));
    check("bp_still_blocked", 128'(in_ready), 0);
    tile_ready = 1'b1;
    @(negedge clk);
    check("bp_nobubble_valid", 128'(tile_valid), 1);
    check("bp_nobubble_data", 128'(tile_data), 128'(seq_tile(8)));
    check("bp_in_ready_back", 128'(in_ready), 1);
    for (int v = 18; v <= 25; v++) send(8'(v), 1'b0);
    idle(3);
    exp_q.push_back({1'b0, seq_tile(1)});
    exp_q.push_back({1'b0, seq_tile(8)});
    exp_q.push_back({1'b0, seq_tile(15)});
    check_tiles("bp");

    // Row end on a partial window, then a fresh row
    do_reset();
    tile_ready = 1'b1;
    for (int v = 1; v <= 13; v++) send(8'(v), v == 13);
    for (int v = 101; v <= 110; v++) send(8'(v), 1'b0);
    idle(3);
    exp_q.push_back({1'b0, seq_tile(1)});
`ifdef WC_ZERO_PAD_EN
    pad = '0;
    for (int i = 0; i < 6; i++) pad[i*8 +: 8] = 8'(8 + i);
    exp_q.push_back({1'b1, pad});
`else
    pad = '0;
`endif
    exp_q.push_back({1'b0, seq_tile(101)});
    check_tiles("partial_row");

    // Row of exactly one tile; next row must not carry overlap
    do_reset();
    for (int v = 1; v <= 10; v++) send(8'(v), v == 10);
    idle(2);
    check("exact_in_ready", 128'(in_ready), 1);
    for (int v = 31; v <= 40; v++) send(8'(v), 1'b0);
    idle(3);
    exp_q.push_back({1'b1, seq_tile(1)});
    exp_q.push_back({1'b0, seq_tile(31)});
    check_tiles("exact_row");

    // Mid-operation reset discards the held tile and the partial window
    do_reset();
    tile_ready = 1'b0;
    for (int v = 1; v <= 15; v++) send(8'(v), 1'b0);
    idle(0);
    check("prerst_valid", 128'(tile_valid), 1);
    rst = 1'b0;
    #1;
    check("midrst_valid", 128'(tile_valid), 0);
    check("midrst_in_ready", 128'(in_ready), 1);
    check("midrst_data", 128'(tile_data), 0);
    @(negedge clk);
    rst = 1'b1;
    tile_ready = 1'b1;
    got_q.delete();
    for (int v = 21; v <= 30; v++) send(8'(v), 1'b0);
    idle(3);
    exp_q.delete();
    exp_q.push_back({1'b0, seq_tile(21)});
    check_tiles("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
